// File: rtl/wb_arbiter_pkg.sv
// Shared types and widths for the writeback arbiter and its per-source FIFOs.
package wb_arbiter_pkg;

  localparam int unsigned NSRC     = 4;
  localparam int unsigned ROBID_W  = 7;
  localparam int unsigned ECAUSE_W = 5;
  localparam int unsigned XLEN     = 32;

  typedef struct packed {
    logic                error;
    logic [ECAUSE_W-1:0] ecause;
    logic [ROBID_W-1:0]  robid;
    logic [XLEN-1:0]     result;
  } wb_pkt_t;

endpackage

// File: rtl/wb_arbiter_fifo2.sv
// Small per-source result FIFO; flush and reset both empty it and drop a same-cycle push.
module wb_fifo2
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_flush,
  input  logic                           i_push,
  input  wb_pkt_t                        i_pkt,
  input  logic                           i_pop,
  output wb_pkt_t                        o_head,
  output logic [$clog2(DEPTH + 1)-1:0]   o_count,
  output logic                           o_empty
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  wb_pkt_t         r_mem [DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            w_push;
  logic            w_pop;

  assign w_push = i_push && (r_count != FullCnt);
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush && !rst) r_mem[r_wr_ptr] <= i_pkt;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: one FIFO per functional-unit source, one registered
// writeback to the ROB per cycle.
module wb_arbiter #(
  parameter int unsigned NSRC  = wb_arbiter_pkg::NSRC,
  parameter int unsigned DEPTH = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NSRC-1:0]                          src_valid,
  output logic [NSRC-1:0]                          src_ready,
  input  logic [NSRC*wb_arbiter_pkg::ROBID_W-1:0]  src_robid,
  input  logic [NSRC-1:0]                          src_error,
  input  logic [NSRC*wb_arbiter_pkg::ECAUSE_W-1:0] src_ecause,
  input  logic [NSRC*wb_arbiter_pkg::XLEN-1:0]     src_result,
  input  logic                                     rob_flush,
  output logic                                     wb_valid,
  output logic                                     wb_error,
  output logic [wb_arbiter_pkg::ECAUSE_W-1:0]      wb_ecause,
  output logic [wb_arbiter_pkg::ROBID_W-1:0]       wb_robid,
  output logic [wb_arbiter_pkg::XLEN-1:0]          wb_result
);

  import wb_arbiter_pkg::wb_pkt_t;
  import wb_arbiter_pkg::ROBID_W;
  import wb_arbiter_pkg::ECAUSE_W;
  import wb_arbiter_pkg::XLEN;

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NSRC - 1);

  wb_pkt_t         w_head  [NSRC];
  logic [CntW-1:0] w_count [NSRC];
  logic [NSRC-1:0] w_empty;
  logic [NSRC-1:0] w_push;
  logic [NSRC-1:0] w_grant;
  logic            w_grant_any;
  logic [IdxW-1:0] w_grant_idx;
  logic [IdxW-1:0] w_rr_ptr_d;
  logic [IdxW-1:0] r_rr_ptr;
  logic            r_wb_valid;
  wb_pkt_t         r_wb_pkt;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    wb_pkt_t w_pkt_in;

    assign w_pkt_in = {src_error[i], src_ecause[i*ECAUSE_W +: ECAUSE_W],
                       src_robid[i*ROBID_W +: ROBID_W], src_result[i*XLEN +: XLEN]};

    // Ready looks only at the registered count, never at this cycle's pop or flush.
    assign src_ready[i] = (w_count[i] < FullCnt) && !rst;
    assign w_push[i]    = src_valid[i] && src_ready[i];

    wb_fifo2 #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (rob_flush),
      .i_push  (w_push[i]),
      .i_pkt   (w_pkt_in),
      .i_pop   (w_grant[i]),
      .o_head  (w_head[i]),
      .o_count (w_count[i]),
      .o_empty (w_empty[i])
    );
  end

  // First non-empty source at or after the round-robin pointer wins.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    w_grant_any = 1'b0;
    w_grant_idx = r_rr_ptr;
    w_grant     = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      idx = (32'(r_rr_ptr) + k) % NSRC;
      if (!w_grant_any && !w_empty[idx]) begin
        w_grant_any = 1'b1;
        w_grant_idx = IdxW'(idx);
      end
    end
    if (w_grant_any) w_grant[w_grant_idx] = 1'b1;
  end

  always_comb begin
    w_rr_ptr_d = r_rr_ptr;
    if (w_grant_any) w_rr_ptr_d = (w_grant_idx == LastIdx) ? '0 : w_grant_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || rob_flush) begin
      r_rr_ptr   <= '0;
      r_wb_valid <= 1'b0;
    end else begin
      r_rr_ptr   <= w_rr_ptr_d;
      r_wb_valid <= w_grant_any;
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant_any) r_wb_pkt <= w_head[w_grant_idx];
  end

  assign wb_valid  = r_wb_valid;
  assign wb_error  = r_wb_pkt.error;
  assign wb_ecause = r_wb_pkt.ecause;
  assign wb_robid  = r_wb_pkt.robid;
  assign wb_result = r_wb_pkt.result;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NSRC, default 4, number of functional-unit result sources (fixed at 4 for this revision).
REQ-002 Parameter DEPTH, default 2, per-source buffer entries.
REQ-003 clk  in  1  clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 src_valid  in  4  per-source result valid.
REQ-006 src_ready  out  4  per-source buffer can accept.
REQ-007 src_robid  in  28  4x7 ROB id, source i at [7i+6:7i].
REQ-008 src_error  in  4  per-source exception flag.
REQ-009 src_ecause  in  20  4x5 exception cause.
REQ-010 src_result  in  128  4x32 result.
REQ-011 rob_flush  in  1  pipeline flush from retirement.
REQ-012 wb_valid  out  1  writeback to ROB valid.
REQ-013 wb_error  out  1  writeback exception flag.
REQ-014 wb_ecause  out  5  writeback cause.
REQ-015 wb_robid  out  7  writeback ROB id.
REQ-016 wb_result  out  32  writeback result.

Function
REQ-017 Each source SHALL own a DEPTH-entry FIFO; push when src_valid[i] & src_ready[i].
REQ-018 src_ready[i] SHALL equal (count_i < DEPTH) & ~rst, combinational from registered count only (no dependence on same-cycle pop).
REQ-019 A FIFO SHALL support push and pop in one cycle; count unchanged.
REQ-020 Each cycle the arbiter SHALL grant at most one non-empty FIFO, round-robin, searching from rr_ptr upward mod 4.
REQ-021 On grant to i, the head entry SHALL pop and rr_ptr SHALL become (i+1) mod 4; no grant, rr_ptr holds.
REQ-022 All wb_* outputs SHALL be registered: granted entry appears at the clock edge ending the grant cycle; wb_valid held exactly one cycle per entry.
REQ-023 Latency: entry pushed at edge k into an empty FIFO with no contention SHALL drive wb_valid after edge k+1.
REQ-024 Fairness: a non-empty FIFO SHALL be granted within 4 cycles.
REQ-025 Per-source ordering SHALL be preserved; no cross-source ordering guarantee.
REQ-026 wb_error/wb_ecause/wb_robid/wb_result SHALL pass through unmodified; when wb_valid=0 their values are don't-care.
REQ-027 rob_flush high at an edge SHALL: zero all counts and pointers, drop same-cycle pushes, clear wb_valid, set rr_ptr=0.
REQ-028 rob_flush SHALL not affect src_ready combinationally in the flush cycle.

Reset
REQ-029 Under rst: all FIFO counts/pointers 0, rr_ptr 0, wb_valid 0, src_ready 4'b0000; first push accepted the cycle after rst falls.
REQ-030 Reset mid-operation SHALL discard all buffered entries with no wb_valid emitted.

Structure
REQ-031 Shared package SHALL hold NSRC, ROBID_W=7, ECAUSE_W=5, XLEN=32 and packed typedef wb_pkt_t {error, ecause, robid, result}.
REQ-032 Sub-module wb_fifo2 (DEPTH-entry FIFO of wb_pkt_t, push/pop/count/flush) SHALL be instantiated once per source; arbiter and output register stay in wb_arbiter.

Verification
REQ-033 Single push src0 robid=5 result=0xDEADBEEF at edge k -> wb_valid after edge k+1, wb_robid=5, wb_result=0xDEADBEEF, one cycle.
REQ-034 All 4 sources push one entry same cycle, rr_ptr=0 -> wb_robid order src0,src1,src2,src3 on 4 consecutive cycles.
REQ-035 src2 held valid continuously, ready low after 2 pushes with no grants possible -> src_ready[2]=0; resumes 1 the cycle after a pop.
REQ-036 rob_flush with 3 FIFOs holding entries -> next cycle wb_valid=0, all src_ready=1, no stale robid ever emitted.
REQ-037 src1 error=1 ecause=5'd4 robid=0x7F -> wb_error=1, wb_ecause=4, wb_robid=0x7F.
REQ-038 Random saturating traffic 10k cycles -> every pushed entry emitted exactly once, per-source order kept, max grant wait <=4 cycles.
